vgaram_arbiter: RTL and testbench
=================================

VGARAM_ARBITER -- requirements
Module: vgaram_arbiter

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-002 Ports SHALL be as follows, in this order:
- clk  in  1  system clock (vga_clk domain)
- reset  in  1  synchronous active-high reset
- cpu_wr_valid  in  1  CPU framebuffer write request
- cpu_wr_ready  out  1  write accepted when valid&ready
- cpu_wr_addr  in  15  byte address (dataaddr[14:0])
- cpu_wr_data  in  8  pixel byte
- vga_x  in  10  current pixel column from timing generator
- vga_y  in  10  current pixel row
- vga_display  in  1  active-video flag
- ram_addr  out  16  single-port framebuffer RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, valid 1 cycle after address
- pix_data  out  8  scanout byte, aligned with pix_display
- pix_display  out  1  vga_display delayed 2 cycles
- fifo_level  out  3  buffered write count, 0..4
- wr_overflow  out  1  sticky: valid seen while not ready
REQ-003 Parameters SHALL be:
- FIFO_DEPTH  4  write buffer entries
- AW  16  RAM address width

Function
REQ-004 A scan slot SHALL occur in every cycle with vga_display=1 and vga_x[1:0]=2'b00.
REQ-005 In a scan slot: ram_addr={1'b0, vga_y[8:2], vga_x[9:2]}, ram_we=0.
REQ-006 A rd_pending flop SHALL be set by the scan slot; in the following cycle the block SHALL register ram_rdata into a hold register.
REQ-007 pix_data SHALL be driven from the hold register. For a scan slot in cycle N, pix_data SHALL take the new byte in cycle N+2 and hold it until the next load.
REQ-008 pix_display SHALL be vga_display delayed by exactly 2 cycles.
REQ-009 Writes SHALL be buffered in a FIFO_DEPTH-entry FIFO of {addr[14:0], data[7:0]}.
- Push on cpu_wr_valid & cpu_wr_ready.
- cpu_wr_ready = (registered count < FIFO_DEPTH), with no combinational path from pop.
REQ-010 In any non-scan-slot cycle with a non-empty FIFO, the block SHALL drain the head entry:
- ram_we=1, ram_addr={1'b0, head.addr}, ram_wdata=head.data
- pop the entry in the same cycle.
REQ-011 Scan slots SHALL have absolute priority over draining; a write SHALL never be issued in a scan slot.
REQ-012 If the FIFO is empty and the cycle is not a scan slot, the block SHALL drive ram_we=0, ram_addr=0, ram_wdata=0.
REQ-013 On a simultaneous push and pop, the count SHALL be unchanged and both operations SHALL take effect. A push into an empty FIFO SHALL be drainable no earlier than the next cycle.
REQ-014 FIFO pointers SHALL be 2-bit and wrap modulo 4; the count SHALL saturate neither below 0 nor above 4 by construction.
REQ-015 wr_overflow SHALL set on cpu_wr_valid & !cpu_wr_ready and clear only on reset.
REQ-016 Writes SHALL drain in FIFO order; at most one RAM access SHALL occur per cycle.

Reset
REQ-017 Reset SHALL clear the following:
- FIFO pointers and count (fifo_level=0); buffered writes are discarded
- rd_pending, hold register (pix_data=0), display delay line (pix_display=0)
- wr_overflow=0.
REQ-018 During reset the outputs SHALL be ram_we=0, ram_addr=0, ram_wdata=0, cpu_wr_ready=0. From the first cycle after reset deasserts, cpu_wr_ready=1.
REQ-019 Reset asserted mid-drain or mid-fetch SHALL abort the operation, with no RAM write in the reset cycle.

Structure
REQ-020 FIFO_DEPTH, AW and the scan-address packing function SHALL live in the shared vga package.
REQ-021 The FIFO SHALL be a sub-module named wr_fifo (push/pop/full/empty/count). Slot decode, read pipeline and mux SHALL stay in vgaram_arbiter.

Verification
REQ-022 Blanking drain: vga_display=0, push 3 writes (0x0010/0xA1, 0x0011/0xA2, 0x7FFF/0xA3) -> RAM writes appear in order on consecutive cycles starting the cycle after the first push; fifo_level returns to 0.
REQ-023 Scanout: RAM preloaded with byte 0x5C at {0,y=8>>2,x=12>>2}; drive vga_x=12, vga_y=8, display=1 -> ram_addr=0x0203 with ram_we=0; pix_data=0x5C two cycles later, and pix_display follows display by 2 cycles.
REQ-024 Contention: display active, 4 writes pushed back-to-back -> no ram_we in any x[1:0]=00 cycle; all 4 written within 6 cycles.
REQ-025 Full: hold drain off via continuous scan slots (force vga_x[1:0]=00), push 5 writes -> 5th refused, cpu_wr_ready=0, wr_overflow=1, fifo_level=4.
REQ-026 Reset mid-operation: reset with fifo_level=3 -> next cycle fifo_level=0, no ram_we, pix_data=0, wr_overflow=0.

Source files
------------

// File: rtl/vgaram_arbiter_pkg.sv
// vgaram_arbiter_pkg: shared framebuffer arbiter constants, write entry type and scan address packing.
package vgaram_arbiter_pkg;
   localparam int FIFO_DEPTH = 4;
   localparam int AW = 16;

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_entry_t;

   // One RAM byte covers a 4x4 pixel block: row from y[8:2], column from x[9:2].
   function automatic logic [AW-1:0] scan_addr(input logic [6:0] row, input logic [7:0] col);
      return {1'b0, row, col};
   endfunction
endpackage

// File: rtl/vgaram_arbiter_wr_fifo.sv
// wr_fifo: CPU write buffer; pointers wrap modulo DEPTH, count tracks occupancy.
module wr_fifo
   import vgaram_arbiter_pkg::*;
#(
   parameter int DEPTH = vgaram_arbiter_pkg::FIFO_DEPTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i_push,
   input  wr_entry_t                      i_din,
   input  logic                           i_pop,
   output wr_entry_t                      o_dout,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   wr_entry_t         r_mem [DEPTH];
   logic [PW-1:0]     r_wp;
   logic [PW-1:0]     r_rp;
   logic [CW-1:0]     r_count;
   logic              w_push;
   logic              w_pop;

   assign o_full  = r_count == CW'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rp];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         r_wp    <= w_push ? r_wp + 1'b1 : r_wp;
         r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_din;
   end
endmodule

// File: rtl/vgaram_arbiter.sv
// vgaram_arbiter: shares one framebuffer RAM port between VGA scanout reads and buffered CPU writes.
module vgaram_arbiter
   import vgaram_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = vgaram_arbiter_pkg::FIFO_DEPTH,
   parameter int AW         = vgaram_arbiter_pkg::AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_wr_valid,
   output logic          cpu_wr_ready,
   input  logic [14:0]   cpu_wr_addr,
   input  logic [7:0]    cpu_wr_data,
   input  logic [9:0]    vga_x,
   input  logic [9:0]    vga_y,
   input  logic          vga_display,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_wdata,
   input  logic [7:0]    ram_rdata,
   output logic [7:0]    pix_data,
   output logic          pix_display,
   output logic [2:0]    fifo_level,
   output logic          wr_overflow
);
   logic       w_scan;
   logic       w_push;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic       w_unused;
   wr_entry_t  w_head;
   logic       r_rd_pending;
   logic [7:0] r_hold;
   logic [1:0] r_disp_dly;
   logic       r_overflow;

   assign w_unused = ^{vga_y[9], vga_y[1:0]};

   wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   ('{addr: cpu_wr_addr, data: cpu_wr_data}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_level)
   );

   // Scan slots win outright; reset silences the RAM port and the CPU handshake.
   always_comb begin
      w_scan       = vga_display && vga_x[1:0] == 2'b00;
      cpu_wr_ready = !reset && !w_full;
      w_push       = cpu_wr_valid && cpu_wr_ready;
      w_pop        = !reset && !w_scan && !w_empty;
      ram_we       = w_pop;
      ram_addr     = (!reset && w_scan) ? AW'(scan_addr(vga_y[8:2], vga_x[9:2])) :
                     w_pop ? AW'({1'b0, w_head.addr}) : '0;
      ram_wdata    = w_pop ? w_head.data : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_pending <= 1'b0;
         r_hold       <= '0;
         r_disp_dly   <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_rd_pending <= w_scan;
         r_hold       <= r_rd_pending ? ram_rdata : r_hold;
         r_disp_dly   <= {r_disp_dly[0], vga_display};
         r_overflow   <= r_overflow || (cpu_wr_valid && !cpu_wr_ready);
      end
   end

   assign pix_data    = r_hold;
   assign pix_display = r_disp_dly[1];
   assign wr_overflow = r_overflow;
endmodule

// File: tb/tb_vgaram_arbiter.sv
// tb_vgaram_arbiter: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_vgaram_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_wr_valid;
   logic        cpu_wr_ready;
   logic [14:0] cpu_wr_addr;
   logic [7:0]  cpu_wr_data;
   logic [9:0]  vga_x;
   logic [9:0]  vga_y;
   logic        vga_display;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  pix_data;
   logic        pix_display;
   logic [2:0]  fifo_level;
   logic        wr_overflow;

   always #5 clk = ~clk;

   vgaram_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_wr_valid (cpu_wr_valid),
      .cpu_wr_ready (cpu_wr_ready),
      .cpu_wr_addr  (cpu_wr_addr),
      .cpu_wr_data  (cpu_wr_data),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_display  (vga_display),
      .ram_addr     (ram_addr),
      .ram_we       (ram_we),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata),
      .pix_data     (pix_data),
      .pix_display  (pix_display),
      .fifo_level   (fifo_level),
      .wr_overflow  (wr_overflow)
   );

   logic [7:0] mem [0:65535] = '{default: 8'h00};
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   typedef struct { logic [14:0] a; logic [7:0] d; } wr_t;
   typedef struct { int t; logic [7:0] v; } px_t;
   typedef struct {
      logic r, v; logic [14:0] a; logic [7:0] d; logic dsp; logic [9:0] x, y;
      logic e_we; logic [15:0] e_addr; logic [7:0] e_wd; logic e_rdy; logic [2:0] e_lvl;
   } vec_t;

   wr_t        wq[$];
   px_t        pq[$];
   logic [7:0] ref_mem [0:65535] = '{default: 8'h00};
   int         t = 0, checks = 0, errors = 0;
   logic       ovf = 1'b0, warm = 1'b0, dh0 = 1'b0, dh1 = 1'b0;
   logic [7:0] pix = 8'h00;
   vec_t       tbl[5];

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", n, t, act, exp);
      end
   endtask

   // Drive one cycle, compare against the model, then advance the model past the coming edge.
   task automatic cyc(input logic r, input logic v, input logic [14:0] a, input logic [7:0] d,
                      input logic dsp, input logic [9:0] x, input logic [9:0] y);
      logic scan, e_we, e_rdy;
      logic [15:0] e_addr;
      logic [7:0] e_wd;
      int xi, yi;
      @(negedge clk);
      reset = r; cpu_wr_valid = v; cpu_wr_addr = a; cpu_wr_data = d;
      vga_display = dsp; vga_x = x; vga_y = y;
      #1;
      xi = int'(x); yi = int'(y);
      scan = dsp && (xi % 4 == 0);
      e_rdy = !r && wq.size() < 4;
      e_we = 1'b0; e_addr = 16'h0; e_wd = 8'h0;
      if (!r && scan) e_addr = 16'(((yi / 4) % 128) * 256 + xi / 4);
      else if (!r && wq.size() > 0) begin
         e_we = 1'b1; e_addr = {1'b0, wq[0].a}; e_wd = wq[0].d;
      end
      while (pq.size() > 0 && pq[0].t == t) begin
         pix = pq[0].v;
         pq.delete(0);
      end
      chk("ram_we", int'(ram_we), int'(e_we));
      chk("ram_addr", int'(ram_addr), int'(e_addr));
      chk("ram_wdata", int'(ram_wdata), int'(e_wd));
      chk("cpu_wr_ready", int'(cpu_wr_ready), int'(e_rdy));
      if (warm) begin
         chk("fifo_level", int'(fifo_level), wq.size());
         chk("wr_overflow", int'(wr_overflow), int'(ovf));
         chk("pix_data", int'(pix_data), int'(pix));
         chk("pix_display", int'(pix_display), int'(dh1));
      end
      if (r) begin
         wq.delete(); pq.delete();
         ovf = 1'b0; pix = 8'h00; dh0 = 1'b0; dh1 = 1'b0; warm = 1'b1;
      end else begin
         if (scan) pq.push_back('{t + 2, ref_mem[e_addr]});
         else if (wq.size() > 0) begin
            ref_mem[{1'b0, wq[0].a}] = wq[0].d;
            wq.delete(0);
         end
         if (v && e_rdy) wq.push_back('{a, d});
         if (v && !e_rdy) ovf = 1'b1;
         dh1 = dh0; dh0 = dsp;
      end
      t++;
   endtask

   initial begin
      int wcnt, swe;
      logic rr, rv, rd;
      logic [14:0] ra;
      tbl[0] = '{0, 1, 15'h0010, 8'hA1, 0, 10'd0, 10'd0, 0, 16'h0000, 8'h00, 1, 3'd0};
      tbl[1] = '{0, 1, 15'h0011, 8'hA2, 0, 10'd0, 10'd0, 1, 16'h0010, 8'hA1, 1, 3'd1};
      tbl[2] = '{0, 1, 15'h7FFF, 8'hA3, 0, 10'd0, 10'd0, 1, 16'h0011, 8'hA2, 1, 3'd1};
      tbl[3] = '{0, 0, 15'h0000, 8'h00, 0, 10'd0, 10'd0, 1, 16'h7FFF, 8'hA3, 1, 3'd1};
      tbl[4] = '{0, 0, 15'h0000, 8'h00, 0, 10'd0, 10'd0, 0, 16'h0000, 8'h00, 1, 3'd0};
      reset = 1'b1; cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
      vga_display = 1'b0; vga_x = '0; vga_y = '0;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("reset_level", int'(fifo_level), 0);
      chk("reset_ready", int'(cpu_wr_ready), 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].dsp, tbl[i].x, tbl[i].y);
         chk($sformatf("tbl%0d_we", i), int'(ram_we), int'(tbl[i].e_we));
         chk($sformatf("tbl%0d_addr", i), int'(ram_addr), int'(tbl[i].e_addr));
         chk($sformatf("tbl%0d_wdata", i), int'(ram_wdata), int'(tbl[i].e_wd));
         chk($sformatf("tbl%0d_ready", i), int'(cpu_wr_ready), int'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_level", i), int'(fifo_level), int'(tbl[i].e_lvl));
      end

      cyc(0, 1, 15'h0203, 8'h5C, 0, 10'd0, 10'd0);
      cyc(0, 0, 0, 0, 0, 10'd0, 10'd0);
      chk("preload_we", int'(ram_we), 1);
      cyc(0, 0, 0, 0, 1, 10'd12, 10'd8);
      chk("scan_addr", int'(ram_addr), 16'h0203);
      chk("scan_we", int'(ram_we), 0);
      cyc(0, 0, 0, 0, 0, 10'd13, 10'd8);
      chk("scan_pd_n1", int'(pix_display), 0);
      cyc(0, 0, 0, 0, 0, 10'd14, 10'd8);
      chk("scan_pix", int'(pix_data), 8'h5C);
      chk("scan_pd_n2", int'(pix_display), 1);

      wcnt = 0; swe = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(0, i < 4, 15'(16'h0100 + i), 8'(8'hB0 + i), 1, 10'(i), 10'd4);
         if (ram_we) wcnt++;
         if (ram_we && i % 4 == 0) swe++;
      end
      chk("contention_writes", wcnt, 4);
      chk("contention_scan_we", swe, 0);

      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 15'(16'h0200 + i), 8'(8'hC0 + i), 1, 10'd12, 10'd8);
         if (i == 4) chk("full_ready", int'(cpu_wr_ready), 0);
      end
      cyc(0, 0, 0, 0, 1, 10'd12, 10'd8);
      chk("full_overflow", int'(wr_overflow), 1);
      chk("full_level", int'(fifo_level), 4);
      cyc(0, 0, 0, 0, 0, 10'd12, 10'd8);
      chk("pre_reset_pix", int'(pix_data), 8'h5C);
      cyc(1, 1, 15'h0001, 8'h11, 1, 10'd12, 10'd8);
      chk("rst_level_before", int'(fifo_level), 3);
      chk("rst_no_we", int'(ram_we), 0);
      chk("rst_addr_zero", int'(ram_addr), 0);
      cyc(0, 0, 0, 0, 0, 10'd1, 10'd0);
      chk("rst_level_after", int'(fifo_level), 0);
      chk("rst_we_after", int'(ram_we), 0);
      chk("rst_pix", int'(pix_data), 0);
      chk("rst_overflow", int'(wr_overflow), 0);
      chk("rst_ready_after", int'(cpu_wr_ready), 1);

      for (int i = 0; i < 3000; i++) begin
         rr = $urandom_range(0, 199) == 0;
         rv = $urandom_range(0, 1) == 1;
         rd = $urandom_range(0, 9) < 7;
         ra = ($urandom_range(0, 3) != 0) ? 15'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7))
                                          : 15'($urandom);
         cyc(rr, rv, ra, 8'($urandom), rd, 10'($urandom_range(0, 31)), 10'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
